spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- SPI initiator for the on-chip register-file SPI slave; drives csn/sclk/mosi and samples miso.
- Issues single and burst reads and writes using the slave command set 0xC1, 0xC5, 0xC2 and 0xCA, framed as command byte, address byte, then data byte(s).
- Sits between a host/sequencer (parallel request interface) and the SPI pins; used as the test/boot-time driver for the slave register file.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (>=1)
- CS_SETUP, 2, clk cycles from csn low to the first sclk rise window (>=1)
- CS_HOLD, 2, clk cycles from the last sclk fall to csn high (>=1)
- CS_GAP, 4, clk cycles csn stays high before done/idle (>=1)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request strobe; sampled only in IDLE
- rnw  in  1  1 = read, 0 = write
- burst  in  1  1 = burst command
- addr  in  8  start address
- len  in  8  burst data bytes minus 1; ignored when burst=0
- wdata  in  8  write data; sampled in the cycle wdata_rd=1
- wdata_rd  out  1  one-clk pulse: wdata consumed
- rdata  out  8  last read byte
- rdata_valid  out  1  one-clk pulse: rdata updated
- busy  out  1  transaction in progress
- done  out  1  one-clk pulse at end of transaction
- csn  out  1  chip select, active-low
- sclk  out  1  SPI clock, idle low
- mosi  out  1  serial data out, MSB first
- miso  in  1  serial data in

Behaviour:
- Reset (async, immediate): csn=1, sclk=0, mosi=0, busy=0, done=0, wdata_rd=0, rdata_valid=0, rdata=0x00, state=IDLE. Reset mid-frame raises csn at once, which also resets the slave.
- Command byte: rnw/burst 1/0 -> 0xC1, 1/1 -> 0xC5, 0/0 -> 0xC2, 0/1 -> 0xCA.
- start in IDLE latches rnw, burst, addr and len. busy=1 from the next cycle. start while busy is ignored, with no queueing.
- States and sequence: IDLE -> SETUP -> CMD -> ADDR -> DATA -> HOLD -> GAP -> IDLE.
  - SETUP: csn=0, sclk=0 for CS_SETUP cycles; mosi = cmd[7].
  - Each bit: low half (CLK_DIV cycles; mosi updated in its first cycle), then high half (CLK_DIV cycles). Mode 0.
  - 8 bits per phase, MSB first. DATA repeats for N = burst ? len+1 : 1 bytes; the byte counter is 9 bits, so len=255 gives 256 bytes.
  - HOLD: sclk=0 for CS_HOLD cycles, then csn=1.
  - GAP: CS_GAP cycles. In its last cycle done=1; busy drops the following cycle.
- Write data: wdata_rd pulses in the first low-half cycle of each data byte. wdata is loaded into the shift register in that same cycle.
- Read data: miso is sampled in the clk cycle where sclk goes 0->1; the slave shifts on its falling edge.
  - After the 8th rise of each data byte, rdata is updated and rdata_valid pulses in the same cycle.
  - miso is ignored in CMD/ADDR and on writes. rdata_valid never asserts for writes.
- mosi is held at the last driven bit during HOLD and driven to 0 in IDLE.
- Frame timing: rise count = 8*(2+N). csn-low duration = CS_SETUP + 16*CLK_DIV*(2+N) + CS_HOLD cycles.
- miso is assumed synchronous to clk; no synchronizer is included.

Optional Feature:
- Macro: SPI_MASTER_ABORT_EN.
- Defined: adds input abort (1) and output aborted (1). abort during DATA ends the frame after the current byte completes: no further wdata_rd or rdata_valid, then HOLD -> GAP, done pulses with aborted=1. aborted clears on the next start. abort outside DATA is ignored.
- Undefined: ports are absent and every frame runs to completion.

Decomposition:
- Package spi_pkg holds the command constants (READ_CMD 0xC1, READ_BURST 0xC5, WRITE_CMD 0xC2, WRITE_BURST 0xCA) and the state enum (IDLE, SETUP, CMD, ADDR, DATA, HOLD, GAP). The slave shares the command constants.
- One sub-module, spi_sclk_gen: half-period counter that produces sclk plus rise/fall strobes, enabled by the FSM.

Test Plan:
- Single write, CLK_DIV=2, addr=0x12, wdata=0x5A: mosi bytes C2,12,5A; 24 sclk rises; 1 wdata_rd; 0 rdata_valid; slave register 0x12 = 0x5A; done 1 pulse.
- Single read, addr=0x12, slave holds 0xA5: mosi C1,12; rdata=0xA5 with 1 rdata_valid; csn low exactly CS_SETUP+16*2*3+CS_HOLD cycles.
- Burst write, len=3, addr=0x20, data 11,22,33,44: mosi CA,20 then the data; 4 wdata_rd; 48 rises; slave 0x20..0x23 hold the data.
- Burst read, len=255, slave preloaded with reg[i]=i: 256 rdata_valid pulses carrying 0x00..0xFF in order.
- Reset asserted mid-ADDR: csn=1, sclk=0 and busy=0 in the same cycle; no done; a later start produces a clean frame.
- start pulsed during busy: ignored, with identical mosi trace. With SPI_MASTER_ABORT_EN, abort in byte 2 of a len=7 burst read: exactly 2 rdata_valid, then aborted=1.

Source files
------------

// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the register-file SPI initiator and slave.
//   - Command byte constants (shared with the slave).
//   - Initiator FSM state enum.
//   - spi_cmd(): command byte for a given rnw/burst request.
package spi_pkg;

  localparam logic [7:0] READ_CMD    = 8'hC1;
  localparam logic [7:0] READ_BURST  = 8'hC5;
  localparam logic [7:0] WRITE_CMD   = 8'hC2;
  localparam logic [7:0] WRITE_BURST = 8'hCA;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CMD,
    ADDR,
    DATA,
    HOLD,
    GAP
  } spi_state_e;

  function automatic logic [7:0] spi_cmd(input logic rnw, input logic burst);
    if (rnw) return burst ? READ_BURST  : READ_CMD;
    else     return burst ? WRITE_BURST : WRITE_CMD;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: half-period divider producing the SPI clock (mode 0, idle low).
//   clk, rst : system clock, async active-high reset
//   en       : run enable from the FSM; low forces sclk=0 and restarts the count
//   sclk     : registered SPI clock
//   rise     : high in the clk cycle whose closing edge takes sclk 0->1
//   fall     : high in the clk cycle whose closing edge takes sclk 1->0
// Each half period lasts CLK_DIV clk cycles; the first half after en rises is low.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = en && (cnt == LAST);
  assign rise = wrap && !sclk;
  assign fall = wrap &&  sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: SPI initiator for the register-file slave.
// Frame: csn low, command byte, address byte, 1 or len+1 data bytes, csn high.
//   clk, rst          : system clock, async active-high reset
//   start             : request strobe, honoured only in IDLE
//   rnw, burst        : request type (selects command 0xC1/0xC5/0xC2/0xCA)
//   addr, len         : start address, burst length minus one
//   wdata / wdata_rd  : write byte, consumed in the cycle wdata_rd pulses
//   rdata/rdata_valid : last read byte and its one-cycle update strobe
//   busy, done        : transaction in progress / one-cycle end-of-frame pulse
//   csn, sclk, mosi, miso : SPI pins (mode 0, MSB first)
// Optional build macro SPI_MASTER_ABORT_EN adds abort (in) and aborted (out):
// abort during DATA ends the frame after the byte in flight.
module spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rnw,
  input  logic       burst,
  input  logic [7:0] addr,
  input  logic [7:0] len,
  input  logic [7:0] wdata,
  output logic       wdata_rd,
  output logic [7:0] rdata,
  output logic       rdata_valid,
  output logic       busy,
  output logic       done,
  output logic       csn,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
`ifdef SPI_MASTER_ABORT_EN
  ,
  input  logic       abort,
  output logic       aborted
`endif
);

  import spi_pkg::*;

  spi_state_e  state;
  logic [15:0] cyc_cnt;    // SETUP / HOLD / GAP dwell counter
  logic [2:0]  bit_cnt;    // bit index within the current byte
  logic [8:0]  byte_cnt;   // data byte index; 9 bits so len=255 gives 256 bytes
  logic [8:0]  last_byte;
  logic        rnw_q;
  logic [7:0]  addr_q;
  logic [7:0]  sh;         // transmit shifter, sh[7] is the bit on the wire
  logic [6:0]  rsh;        // first seven received bits of the current byte
  logic        sclk_en;
  logic        rise, fall;
  logic        stop_req;

`ifdef SPI_MASTER_ABORT_EN
  logic abort_pend;
  assign stop_req = abort_pend | abort;
`else
  assign stop_req = 1'b0;
`endif

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .en   (sclk_en),
    .sclk (sclk),
    .rise (rise),
    .fall (fall)
  );

  // wdata is taken into the shifter at the end of the wdata_rd cycle; during
  // that one cycle the first data bit comes straight from wdata so mosi is
  // valid from the first low-half cycle, even when CLK_DIV=1.
  assign mosi = wdata_rd ? wdata[7] : sh[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cyc_cnt     <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      last_byte   <= '0;
      rnw_q       <= 1'b0;
      addr_q      <= '0;
      sh          <= '0;
      rsh         <= '0;
      sclk_en     <= 1'b0;
      csn         <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      wdata_rd    <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
`ifdef SPI_MASTER_ABORT_EN
      abort_pend  <= 1'b0;
      aborted     <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      wdata_rd    <= 1'b0;
      rdata_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SETUP;
            rnw_q     <= rnw;
            addr_q    <= addr;
            last_byte <= burst ? {1'b0, len} : 9'd0;
            sh        <= spi_cmd(rnw, burst);
            cyc_cnt   <= '0;
            csn       <= 1'b0;
            busy      <= 1'b1;
`ifdef SPI_MASTER_ABORT_EN
            abort_pend <= 1'b0;
            aborted    <= 1'b0;
`endif
          end
        end

        SETUP: begin
          if (cyc_cnt == 16'(CS_SETUP - 1)) begin
            state   <= CMD;
            sclk_en <= 1'b1;
            bit_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        CMD, ADDR, DATA: begin
`ifdef SPI_MASTER_ABORT_EN
          if (state == DATA && abort) abort_pend <= 1'b1;
`endif
          if (state == DATA && wdata_rd) sh <= wdata;

          // Slave shifts on the falling edge, so miso is stable at each rise.
          if (state == DATA && rise && rnw_q) begin
            if (bit_cnt == 3'd7) begin
              rdata       <= {rsh, miso};
              rdata_valid <= 1'b1;
            end else begin
              rsh <= {rsh[5:0], miso};
            end
          end

          if (fall) begin
            if (bit_cnt != 3'd7) begin
              bit_cnt <= bit_cnt + 3'd1;
              sh      <= {sh[6:0], 1'b0};
            end else begin
              bit_cnt <= '0;
              if (state == CMD) begin
                state <= ADDR;
                sh    <= addr_q;
              end else if (state == ADDR) begin
                state    <= DATA;
                byte_cnt <= '0;
                sh       <= '0;
                wdata_rd <= !rnw_q;
              end else if (byte_cnt == last_byte || stop_req) begin
                // Leave sh alone: mosi keeps the last driven bit in HOLD.
                state   <= HOLD;
                sclk_en <= 1'b0;
                cyc_cnt <= '0;
`ifdef SPI_MASTER_ABORT_EN
                aborted <= stop_req;
`endif
              end else begin
                byte_cnt <= byte_cnt + 9'd1;
                sh       <= '0;
                wdata_rd <= !rnw_q;
              end
            end
          end
        end

        HOLD: begin
          if (cyc_cnt == 16'(CS_HOLD - 1)) begin
            state   <= GAP;
            csn     <= 1'b1;
            cyc_cnt <= '0;
            done    <= (CS_GAP == 1);
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
          end
        end

        GAP: begin
          // done is registered, so it is raised one cycle ahead of the exit.
          if (cyc_cnt == 16'(CS_GAP - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            sh    <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 16'd1;
            done    <= (int'(cyc_cnt) == CS_GAP - 2);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed + randomized bench for spi_master with a behavioural
// register-file slave. Expected frame shape, counts and data come from the
// transaction description; the slave only records what arrives on the wire.
module tb_spi_master;

  localparam int CLK_DIV  = 2;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;
  localparam int LIMIT    = 20000;

  logic       clk = 1'b0;
  logic       rst, start, rnw, burst;
  logic [7:0] addr, len, wdata;
  logic       wdata_rd, rdata_valid, busy, done, csn, sclk, mosi;
  logic [7:0] rdata;
  logic       miso = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
  logic       abort, aborted;
`endif

  int vecs = 0;
  int miss = 0;

  spi_master #(.CLK_DIV(CLK_DIV), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .rnw(rnw), .burst(burst), .addr(addr),
    .len(len), .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata),
    .rdata_valid(rdata_valid), .busy(busy), .done(done), .csn(csn), .sclk(sclk),
    .mosi(mosi), .miso(miso)
`ifdef SPI_MASTER_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave ----------------
  logic [7:0]  mem [256];       // slave register file, written only by the main flow
  logic [7:0]  mosi_q [$];      // every byte seen on mosi in the current frame
  logic [15:0] wr_q [$];        // {addr,data} writes the slave would perform
  int          sl_cnt = 0;
  logic [7:0]  sl_sh = '0, sl_cmd = '0, sl_ptr = '0, sl_tx = '0;

  always @(negedge csn) sl_cnt = 0;

  always @(posedge sclk) if (!csn) begin
    sl_sh = {sl_sh[6:0], mosi};
    sl_cnt++;
    if (sl_cnt % 8 == 0) begin
      mosi_q.push_back(sl_sh);
      if (sl_cnt == 8) sl_cmd = sl_sh;
      else if (sl_cnt == 16) sl_ptr = sl_sh;
      else if (sl_cmd == 8'hC2 || sl_cmd == 8'hCA) begin
        wr_q.push_back({sl_ptr, sl_sh});
        sl_ptr++;
      end
    end
  end

  always @(negedge sclk) if (!csn) begin
    if (sl_cnt >= 16 && sl_cnt % 8 == 0 && (sl_cmd == 8'hC1 || sl_cmd == 8'hC5)) begin
      sl_tx = mem[sl_ptr];
      sl_ptr++;
    end else begin
      sl_tx = {sl_tx[6:0], 1'b0};
    end
    miso = sl_tx[7];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_cmd(input logic r, input logic b);
    if (r) return b ? 8'hC5 : 8'hC1;
    return b ? 8'hCA : 8'hC2;
  endfunction

  logic [7:0] wq [256];   // bytes the host offers for the next write

  // One transaction. extra_start >= 0 pulses start again at that cycle;
  // abort_rise >= 0 pulses abort at that sclk rise count and abort_bytes is
  // the number of data bytes then expected.
  task automatic do_txn(input logic r, input logic b, input logic [7:0] a,
                        input logic [7:0] l, input int extra_start,
                        input int abort_rise, input int abort_bytes);
    int ne, rises, csn_low, nwr, ndone, wi;
    logic sclk_prev, feed, got_abort;
    logic [7:0] rd_q [$];
    ne = (abort_bytes > 0) ? abort_bytes : (b ? int'(l) + 1 : 1);
    rises = 0; csn_low = 0; nwr = 0; ndone = 0; wi = 0;
    sclk_prev = 1'b0; feed = 1'b0; got_abort = 1'b0;
    mosi_q.delete(); wr_q.delete();
    rnw = r; burst = b; addr = a; len = l; wdata = wq[0]; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int cyc = 0; cyc < LIMIT; cyc++) begin
      if (feed) begin
        wi++;
        wdata = wq[wi[7:0]];
        feed = 1'b0;
      end
      if (!csn) csn_low++;
      if (sclk && !sclk_prev) rises++;
      sclk_prev = sclk;
      if (wdata_rd) begin nwr++; feed = 1'b1; end
      if (rdata_valid) rd_q.push_back(rdata);
      if (done) begin
        ndone++;
`ifdef SPI_MASTER_ABORT_EN
        chk("aborted_at_done", {31'd0, aborted}, {31'd0, abort_rise >= 0});
`endif
        break;
      end
      start = (cyc == extra_start);
`ifdef SPI_MASTER_ABORT_EN
      abort = 1'b0;
      if (abort_rise >= 0 && rises == abort_rise && !got_abort) begin
        abort = 1'b1;
        got_abort = 1'b1;
      end
`endif
      @(posedge clk); #1;
    end
    start = 1'b0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    chk("done_pulses", 32'(ndone), 32'd1);
    chk("sclk_rises", 32'(rises), 32'(8 * (2 + ne)));
    chk("csn_low_cycles", 32'(csn_low), 32'(CS_SETUP + 16 * CLK_DIV * (2 + ne) + CS_HOLD));
    chk("wdata_rd_count", 32'(nwr), r ? 32'd0 : 32'(ne));
    chk("rdata_valid_count", 32'(rd_q.size()), r ? 32'(ne) : 32'd0);
    chk("mosi_byte_count", 32'(mosi_q.size()), 32'(2 + ne));
    if (mosi_q.size() >= 2) begin
      chk("mosi_cmd", {24'd0, mosi_q[0]}, {24'd0, exp_cmd(r, b)});
      chk("mosi_addr", {24'd0, mosi_q[1]}, {24'd0, a});
    end
    if (r) begin
      for (int i = 0; i < rd_q.size() && i < ne; i++)
        chk("rdata", {24'd0, rd_q[i]}, {24'd0, mem[8'(int'(a) + i)]});
    end else begin
      chk("slave_write_count", 32'(wr_q.size()), 32'(ne));
      for (int i = 0; i < wr_q.size() && i < ne; i++) begin
        chk("slave_write", {16'd0, wr_q[i]}, {16'd0, 8'(int'(a) + i), wq[i]});
        mem[wr_q[i][15:8]] = wr_q[i][7:0];
      end
    end
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_csn", {31'd0, csn}, 32'd1);
    chk("idle_mosi", {31'd0, mosi}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       r, b;
    logic [7:0] a, l;
    rst = 1'b1; start = 1'b0; rnw = 1'b0; burst = 1'b0;
    addr = '0; len = '0; wdata = '0;
`ifdef SPI_MASTER_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'($urandom);
      wq[i]  = 8'($urandom);
    end
    #12;
    chk("rst_csn", {31'd0, csn}, 32'd1);
    chk("rst_sclk", {31'd0, sclk}, 32'd0);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wdata_rd", {31'd0, wdata_rd}, 32'd0);
    chk("rst_rdata_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single write 0x5A -> 0x12, then single read of 0xA5 from 0x12
    wq[0] = 8'h5A;
    do_txn(1'b0, 1'b0, 8'h12, 8'h00, -1, -1, 0);
    chk("reg12_after_write", {24'd0, mem[8'h12]}, 32'h5A);
    mem[8'h12] = 8'hA5;
    do_txn(1'b1, 1'b0, 8'h12, 8'h00, -1, -1, 0);

    // burst write of four bytes at 0x20
    wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33; wq[3] = 8'h44;
    do_txn(1'b0, 1'b1, 8'h20, 8'd3, -1, -1, 0);

    // full 256-byte burst read of reg[i]=i
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    do_txn(1'b1, 1'b1, 8'h00, 8'hFF, -1, -1, 0);

    // reset during the address byte: pins and busy drop at once, no done
    rnw = 1'b1; burst = 1'b0; addr = 8'h33; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (CS_SETUP + 2 * CLK_DIV * 10) @(posedge clk);
    #2; rst = 1'b1; #1;
    chk("midrst_csn", {31'd0, csn}, 32'd1);
    chk("midrst_sclk", {31'd0, sclk}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("midrst_no_done", {31'd0, done}, 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) wq[i] = 8'($urandom);
    do_txn(1'b0, 1'b1, 8'($urandom), 8'd3, -1, -1, 0);

    // start pulsed mid-frame must not disturb the trace or queue a frame
    for (int i = 0; i < 3; i++) wq[i] = 8'($urandom);
    do_txn(1'b0, 1'b1, 8'h80, 8'd2, 20, -1, 0);

    // randomized mix of reads and writes
    for (int k = 0; k < 8; k++) begin
      r = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      a = 8'($urandom);
      l = 8'($urandom_range(0, 7));
      for (int i = 0; i < 8; i++) wq[i] = 8'($urandom);
      do_txn(r, b, a, l, -1, -1, 0);
    end

`ifdef SPI_MASTER_ABORT_EN
    // abort during data byte 2 of an 8-byte burst read
    do_txn(1'b1, 1'b1, 8'h40, 8'd7, -1, 8 * 3 + 3, 2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
